// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: stall and forwarding control for the 5-stage MIPS pipeline.
//
// This block tracks the destination register and result latency (Tnew) of each
// instruction in the E, M and W stages. It compares them against the operand
// needs (Tuse) of the instructions in D and E. From that comparison it produces
// the stall request and the select codes for the forwarding MUXes.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset, clears all stage state
//   d_rs/d_rt  : source registers of the instruction in D
//   d_tuse_rs  : cycles until D needs rs (3 = operand not used)
//   d_tuse_rt  : cycles until D needs rt (3 = operand not used)
//   d_a3       : destination register of the instruction in D (0 = no write)
//   d_tnew     : cycles after E entry until the D instruction's result exists
//   stall      : freeze PC/D and inject a bubble into E
//   fwd_d_rs   : D-stage rs forward select
//   fwd_d_rt   : D-stage rt forward select
//   fwd_e_rs   : E-stage rs forward select
//   fwd_e_rt   : E-stage rt forward select
//                (all selects: 00 none, 01 M, 10 W, 11 E)
//   e_a3       : tracked destination register in E
//   m_a3       : tracked destination register in M
//   w_a3       : tracked destination register in W

module hazard_forward_unit #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned T_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic [T_W-1:0]   d_tuse_rs,
  input  logic [T_W-1:0]   d_tuse_rt,
  input  logic [REG_W-1:0] d_a3,
  input  logic [T_W-1:0]   d_tnew,
  output logic             stall,
  output logic [1:0]       fwd_d_rs,
  output logic [1:0]       fwd_d_rt,
  output logic [1:0]       fwd_e_rs,
  output logic [1:0]       fwd_e_rt,
  output logic [REG_W-1:0] e_a3,
  output logic [REG_W-1:0] m_a3,
  output logic [REG_W-1:0] w_a3
);

  localparam logic [1:0] FwdNone = 2'b00;
  localparam logic [1:0] FwdM    = 2'b01;
  localparam logic [1:0] FwdW    = 2'b10;
  localparam logic [1:0] FwdE    = 2'b11;

  // An all-ones Tuse marks an operand that is never read.
  localparam logic [T_W-1:0] TuseNone = {T_W{1'b1}};
  localparam logic [T_W-1:0] TnewOne  = T_W'(1);

  // Stage state
  logic [REG_W-1:0] e_a3_q, e_rs_q, e_rt_q;
  logic [T_W-1:0]   e_tnew_q, e_tuse_rs_q, e_tuse_rt_q;
  logic [REG_W-1:0] m_a3_q;
  logic [T_W-1:0]   m_tnew_q;
  logic [REG_W-1:0] w_a3_q;
  logic [T_W-1:0]   w_tnew_q;

  // Tnew counts down once per stage and saturates at zero.
  function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : (t - TnewOne);
  endfunction

  // Register $0 is hard-wired, so it never matches a producer.
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  // Stall when the nearest producer of src cannot deliver by the time it is used.
  // W always has its result ready, so only E and M are considered.
  function automatic logic operand_stall(input logic [REG_W-1:0] src,
                                         input logic [T_W-1:0]   tuse,
                                         input logic [REG_W-1:0] ea3,
                                         input logic [T_W-1:0]   etnew,
                                         input logic [REG_W-1:0] ma3,
                                         input logic [T_W-1:0]   mtnew);
    logic s;
    s = 1'b0;
    if (tuse != TuseNone) begin
      if (reg_match(src, ea3) && (etnew > tuse)) s = 1'b1;
      if (reg_match(src, ma3) && (mtnew > tuse)) s = 1'b1;
    end
    return s;
  endfunction

  // D-stage select: only the youngest matching stage is considered. A producer
  // that is not ready yet yields "no forward", and the stall logic covers it.
  function automatic logic [1:0] fwd_d_sel(input logic [REG_W-1:0] src,
                                           input logic [REG_W-1:0] ea3,
                                           input logic [T_W-1:0]   etnew,
                                           input logic [REG_W-1:0] ma3,
                                           input logic [T_W-1:0]   mtnew,
                                           input logic [REG_W-1:0] wa3);
    logic [1:0] sel;
    if (reg_match(src, ea3)) begin
      sel = (etnew == '0) ? FwdE : FwdNone;
    end else if (reg_match(src, ma3)) begin
      sel = (mtnew == '0) ? FwdM : FwdNone;
    end else if (reg_match(src, wa3)) begin
      sel = FwdW;
    end else begin
      sel = FwdNone;
    end
    return sel;
  endfunction

  // E-stage select: the producers are in M and W only.
  function automatic logic [1:0] fwd_e_sel(input logic [REG_W-1:0] src,
                                           input logic [REG_W-1:0] ma3,
                                           input logic [T_W-1:0]   mtnew,
                                           input logic [REG_W-1:0] wa3);
    logic [1:0] sel;
    if (reg_match(src, ma3)) begin
      sel = (mtnew == '0) ? FwdM : FwdNone;
    end else if (reg_match(src, wa3)) begin
      sel = FwdW;
    end else begin
      sel = FwdNone;
    end
    return sel;
  endfunction

  logic rs_stall, rt_stall;

  always_comb begin
    rs_stall = operand_stall(d_rs, d_tuse_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    rt_stall = operand_stall(d_rt, d_tuse_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    stall    = rs_stall | rt_stall;

    fwd_d_rs = fwd_d_sel(d_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
    fwd_d_rt = fwd_d_sel(d_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
    fwd_e_rs = fwd_e_sel(e_rs_q, m_a3_q, m_tnew_q, w_a3_q);
    fwd_e_rt = fwd_e_sel(e_rt_q, m_a3_q, m_tnew_q, w_a3_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_a3_q      <= '0;
      e_rs_q      <= '0;
      e_rt_q      <= '0;
      e_tnew_q    <= '0;
      e_tuse_rs_q <= '0;
      e_tuse_rt_q <= '0;
      m_a3_q      <= '0;
      m_tnew_q    <= '0;
      w_a3_q      <= '0;
      w_tnew_q    <= '0;
    end else begin
      w_a3_q   <= m_a3_q;
      w_tnew_q <= tnew_dec(m_tnew_q);
      m_a3_q   <= e_a3_q;
      m_tnew_q <= tnew_dec(e_tnew_q);
      if (stall) begin
        // A bubble writes nothing and reads nothing.
        e_a3_q      <= '0;
        e_rs_q      <= '0;
        e_rt_q      <= '0;
        e_tnew_q    <= '0;
        e_tuse_rs_q <= TuseNone;
        e_tuse_rt_q <= TuseNone;
      end else begin
        e_a3_q      <= d_a3;
        e_rs_q      <= d_rs;
        e_rt_q      <= d_rt;
        e_tnew_q    <= d_tnew;
        e_tuse_rs_q <= d_tuse_rs;
        e_tuse_rt_q <= d_tuse_rt;
      end
    end
  end

  assign e_a3 = e_a3_q;
  assign m_a3 = m_a3_q;
  assign w_a3 = w_a3_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [4:0] e_a3, m_a3, w_a3;

  int total = 0;
  int bad   = 0;

  hazard_forward_unit #(
    .REG_W(5),
    .T_W  (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .d_rs     (d_rs),
    .d_rt     (d_rt),
    .d_tuse_rs(d_tuse_rs),
    .d_tuse_rt(d_tuse_rt),
    .d_a3     (d_a3),
    .d_tnew   (d_tnew),
    .stall    (stall),
    .fwd_d_rs (fwd_d_rs),
    .fwd_d_rt (fwd_d_rt),
    .fwd_e_rs (fwd_e_rs),
    .fwd_e_rt (fwd_e_rt),
    .e_a3     (e_a3),
    .m_a3     (m_a3),
    .w_a3     (w_a3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                       input logic [1:0] trt, input logic [4:0] a3, input logic [1:0] tnew);
    d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt; d_a3 = a3; d_tnew = tnew;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    set_d(0, 0, 3, 3, 0, 0);
    tick(); tick(); tick();
  endtask

  initial begin
    reset = 1'b0;
    set_d(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_fwd", {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}, 0);
    reset = 1'b1;
    tick(); tick();
    // 1: all-zero inputs after reset
    chk("idle_stall", stall, 0);
    chk("idle_fwd", {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}, 0);
    chk("idle_a3", {e_a3, m_a3, w_a3}, 0);

    // 2: load-use
    set_d(0, 0, 3, 3, 8, 2);
    tick();
    chk("lu_e_a3", e_a3, 8);
    set_d(8, 0, 1, 3, 0, 0);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_m_a3", m_a3, 8);
    chk("lu_e_bubble", e_a3, 0);
    chk("lu_stall_drop", stall, 0);
    chk("lu_fwd_d_rs_m_notready", fwd_d_rs, 2'b00);
    tick();
    set_d(0, 0, 3, 3, 0, 0);
    chk("lu_w_a3", w_a3, 8);
    chk("lu_fwd_e_rs_w", fwd_e_rs, 2'b10);
    flush();

    // 3: ALU to ALU
    set_d(0, 0, 3, 3, 9, 1);
    tick();
    set_d(9, 0, 1, 3, 0, 0);
    chk("alu_stall", stall, 0);
    chk("alu_fwd_d_rs", fwd_d_rs, 2'b00);
    tick();
    set_d(0, 0, 3, 3, 0, 0);
    chk("alu_fwd_e_rs_m", fwd_e_rs, 2'b01);
    chk("alu_fwd_e_rt", fwd_e_rt, 2'b00);
    flush();

    // 4: jal then beq
    set_d(0, 0, 3, 3, 31, 0);
    tick();
    set_d(31, 0, 0, 3, 0, 0);
    chk("jal_stall", stall, 0);
    chk("jal_fwd_d_rs_e", fwd_d_rs, 2'b11);
    flush();

    // 5: nearest stage wins
    set_d(0, 0, 3, 3, 5, 1);
    tick();
    set_d(0, 0, 3, 3, 5, 1);
    tick();
    set_d(0, 5, 3, 2, 0, 0);
    chk("near_fwd_d_rt", fwd_d_rt, 2'b00);
    chk("near_stall", stall, 0);
    set_d(0, 5, 3, 0, 0, 0);
    chk("near_rt_stall", stall, 1);
    set_d(5, 5, 0, 0, 0, 0);
    chk("both_stall", stall, 1);
    chk("both_fwd_same", {fwd_d_rs, fwd_d_rt}, 4'b0000);
    flush();

    // D-stage forward from M and from W
    set_d(0, 0, 3, 3, 12, 1);
    tick();
    set_d(0, 0, 3, 3, 0, 0);
    tick();
    set_d(12, 0, 0, 3, 0, 0);
    chk("dm_fwd_d_rs", fwd_d_rs, 2'b01);
    chk("dm_stall", stall, 0);
    set_d(0, 0, 3, 3, 0, 0);
    tick();
    set_d(12, 12, 0, 0, 0, 0);
    chk("dw_fwd_d", {fwd_d_rs, fwd_d_rt}, 4'b1010);
    flush();

    // Tuse = 3 never stalls
    set_d(0, 0, 3, 3, 6, 2);
    tick();
    set_d(6, 6, 3, 3, 0, 0);
    chk("tuse3_stall", stall, 0);
    flush();

    // 6: $0 never hazards, then reset mid-stall
    set_d(0, 0, 3, 3, 0, 2);
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    chk("r0_stall", stall, 0);
    chk("r0_fwd", fwd_d_rs, 2'b00);
    set_d(0, 0, 3, 3, 8, 2);
    tick();
    set_d(8, 0, 0, 3, 0, 0);
    chk("pre_rst_stall", stall, 1);
    chk("pre_rst_e_a3", e_a3, 8);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_stall", stall, 0);
    chk("async_rst_a3", {e_a3, m_a3, w_a3}, 0);
    set_d(0, 0, 3, 3, 0, 0);
    reset = 1'b1;
    tick();
    chk("restart_a3", {e_a3, m_a3, w_a3}, 0);
    chk("restart_stall", stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
